negedge_reader: RTL and testbench
=================================

# negedge_reader

Receiving end of the falling-edge launch interface. An upstream writer registers `XIN`/`XVALID` on `negedge CLK`, and this block samples them on the following `posedge CLK`. Accepted words go into a small show-ahead FIFO that drains through a ready/valid port, so falling-edge producers can feed rising-edge logic without a second clock. Flow control back to the writer uses `XREADY`, which changes only on rising edges and so is stable when the writer samples it on the falling edge.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 4: FIFO entries. Any value ≥ 2 is legal; it need not be a power of two.
- `CLK`  in  1  single clock. Storage and all state update on the rising edge only.
- `RESET`  in  1  asynchronous reset, active-high.
- `XIN`  in  WIDTH  write data, launched by the writer on the falling edge.
- `XVALID`  in  1  write strobe, launched by the writer on the falling edge.
- `XREADY`  out  1  FIFO can accept a word at the next rising edge.
- `DOUT`  out  WIDTH  head-of-FIFO data (show-ahead).
- `DVALID`  out  1  `DOUT` holds a valid word.
- `DREADY`  in  1  consumer accepts `DOUT` at this rising edge.
- `COUNT`  out  clog2(DEPTH+1)  number of entries currently held.
- `OVERFLOW`  out  1  sticky error flag.

## Operation
- State: storage array, write pointer `wp`, read pointer `rp`, `COUNT`, `OVERFLOW`.
- Push: at a rising edge with `XVALID && XREADY`:
  - write `XIN` into entry `wp`;
  - `wp` advances to `wp+1`, or to 0 when `wp == DEPTH-1`.
- Pop: at a rising edge with `DVALID && DREADY`:
  - `rp` advances with the same wrap rule.
- `COUNT` update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop, or when neither occurs.
- `XREADY` is `COUNT < DEPTH` and is forced to 0 while `RESET` is high.
  - When full, `XREADY` stays 0 during a same-cycle pop. The freed slot is advertised only after the edge.
- `DVALID` is `COUNT != 0`.
- `DOUT` is entry `rp` when `DVALID` is 1, otherwise all-zero.
- Overflow: `XVALID` high with `XREADY` low at a rising edge:
  - the word is dropped;
  - `OVERFLOW` sets to 1;
  - FIFO state is unchanged.
  - `OVERFLOW` clears only on reset.
- Empty:
  - `DREADY` with `DVALID` low has no effect;
  - on a push into an empty FIFO, that word appears on `DOUT` after the same edge.
- `COUNT` saturates neither up nor down; the rules above keep it within 0..DEPTH.

## Timing
- Reset (asynchronous; takes effect immediately, independent of `CLK`):
  - `wp`, `rp` and `COUNT` go to 0;
  - `DVALID` = 0, `DOUT` = 0, `OVERFLOW` = 0, `XREADY` = 0.
- Reset mid-operation discards all stored words. Storage contents need not be cleared.
- After `RESET` falls, `XREADY` = 1 combinationally. The first push can happen at the first rising edge with `RESET` low.
- Latency:
  - a word launched at falling edge N−½ is sampled at rising edge N;
  - it is visible on `DOUT`/`DVALID` after edge N when the FIFO was empty;
  - the earliest pop is at edge N+1.
- Throughput: one push and one pop per cycle, sustained, when neither full nor empty.
- All outputs change only after a rising edge or on `RESET`. Nothing changes on the falling edge.

## Test plan
- Reset then idle: assert `RESET` mid-cycle with no clock edge.
  - Required: all outputs go to 0 at once.
  - After release: `XREADY` = 1, `COUNT` = 0.
- Single word: writer drives `XIN` = 0xA5 and `XVALID` on a falling edge, `DREADY` = 0.
  - After the next rising edge: `DVALID` = 1, `DOUT` = 0xA5, `COUNT` = 1.
  - With `DREADY` = 1 at the following edge: empty, `DOUT` = 0.
- Fill and overflow: push 0x01..0x04 (`DEPTH` = 4), then push 0x05.
  - Required: `XREADY` = 0 after the 4th edge, 0x05 dropped, `OVERFLOW` = 1.
  - Drain: 0x01, 0x02, 0x03, 0x04 in order.
- Full with simultaneous push and pop: at `COUNT` = 4, present `XVALID` and `DREADY` together.
  - Required: pop 0x01, push refused, `OVERFLOW` = 1, `COUNT` = 3, then `XREADY` = 1.
- Wrap-around streaming: 20 consecutive words 0x10..0x23, continuous push and pop with `DREADY` = 1.
  - Required: output order preserved across pointer wraps, `COUNT` constant at 1, `OVERFLOW` = 0.
- Reset mid-stream: assert `RESET` with `COUNT` = 3.
  - Required: `COUNT` = 0, `DVALID` = 0, `OVERFLOW` cleared.
  - Next pushed word 0x77 appears as head.

Source files
------------

// File: rtl/negedge_reader_if.sv
// Bundle between a falling-edge writer, the negedge_reader FIFO and its ready/valid consumer.
// The reader block uses the slave view; a writer/consumer model uses the master view.
interface negedge_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] XIN;
  logic             XVALID;
  logic             XREADY;
  logic [WIDTH-1:0] DOUT;
  logic             DVALID;
  logic             DREADY;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;

  modport slave (
    input  XIN, XVALID, DREADY,
    output XREADY, DOUT, DVALID, COUNT, OVERFLOW
  );

  modport master (
    output XIN, XVALID, DREADY,
    input  XREADY, DOUT, DVALID, COUNT, OVERFLOW
  );
endinterface

// File: rtl/negedge_reader.sv
// Rising-edge receiver for a falling-edge launched write port, buffered in a show-ahead FIFO.
// XREADY depends only on rising-edge state, so it is stable when the writer samples it on the falling edge.
module negedge_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  negedge_reader_if.slave bus
);
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic xready;
  logic dvalid;
  logic push;
  logic pop;

  // A pop in the same cycle never frees a slot early: XREADY looks only at the registered count.
  assign xready = !RESET && (count_q < FULL);
  assign dvalid = (count_q != '0);
  assign push   = bus.XVALID && xready;
  assign pop    = dvalid && bus.DREADY;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
    if (pop)  rp_d = (rp_q == LAST) ? '0 : rp_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (bus.XVALID && !xready) ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; COUNT/DVALID already mask stale entries.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= bus.XIN;
  end

  assign bus.XREADY   = xready;
  assign bus.DVALID   = dvalid;
  assign bus.DOUT     = dvalid ? mem_q[rp_q] : '0;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = ovf_q;
endmodule

// File: tb/tb_negedge_reader.sv
// Directed bench for negedge_reader: writer drives on the falling edge, outputs are checked 1 time unit after each rising edge.
module tb_negedge_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic CLK;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  negedge_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  negedge_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One writer/consumer cycle: launch on the falling edge, then land 1 unit past the rising edge.
  task automatic step(input logic xv, input logic [WIDTH-1:0] xin, input logic dr);
    @(negedge CLK);
    bus.XVALID = xv;
    bus.XIN    = xin;
    bus.DREADY = dr;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET      = 1'b1;
    bus.XVALID = 1'b0;
    bus.XIN    = '0;
    bus.DREADY = 1'b0;

    // Reset before any clock edge
    #1;
    check("rst_xready", bus.XREADY, 0);
    check("rst_dvalid", bus.DVALID, 0);
    check("rst_dout", bus.DOUT, 0);
    check("rst_count", bus.COUNT, 0);
    check("rst_ovf", bus.OVERFLOW, 0);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rel_xready", bus.XREADY, 1);
    check("rel_count", bus.COUNT, 0);

    // DREADY on an empty FIFO does nothing
    step(1'b0, 8'h00, 1'b1);
    check("empty_pop_count", bus.COUNT, 0);
    check("empty_pop_dvalid", bus.DVALID, 0);

    // Single word
    step(1'b1, 8'hA5, 1'b0);
    check("single_dvalid", bus.DVALID, 1);
    check("single_dout", bus.DOUT, 8'hA5);
    check("single_count", bus.COUNT, 1);
    step(1'b0, 8'h00, 1'b1);
    check("single_pop_dvalid", bus.DVALID, 0);
    check("single_pop_dout", bus.DOUT, 0);
    check("single_pop_count", bus.COUNT, 0);

    // Streaming 0x10..0x23 with continuous push and pop across pointer wraps
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1);
      check("stream_dout", bus.DOUT, 32'(8'h10 + i));
      check("stream_count", bus.COUNT, 1);
    end
    step(1'b0, 8'h00, 1'b1);
    check("stream_end_dvalid", bus.DVALID, 0);
    check("stream_ovf", bus.OVERFLOW, 0);

    // Fill to DEPTH, then overflow
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    check("full_xready", bus.XREADY, 0);
    check("full_count", bus.COUNT, 4);
    check("full_head", bus.DOUT, 8'h01);
    check("full_ovf_clear", bus.OVERFLOW, 0);
    step(1'b1, 8'h05, 1'b0);
    check("ovf_set", bus.OVERFLOW, 1);
    check("ovf_count", bus.COUNT, 4);
    check("ovf_head", bus.DOUT, 8'h01);
    step(1'b0, 8'h00, 1'b1);
    check("drain_02", bus.DOUT, 8'h02);
    check("drain_xready", bus.XREADY, 1);
    step(1'b0, 8'h00, 1'b1);
    check("drain_03", bus.DOUT, 8'h03);
    step(1'b0, 8'h00, 1'b1);
    check("drain_04", bus.DOUT, 8'h04);
    step(1'b0, 8'h00, 1'b1);
    check("drain_empty_dvalid", bus.DVALID, 0);
    check("drain_empty_dout", bus.DOUT, 0);
    check("drain_ovf_sticky", bus.OVERFLOW, 1);

    // Full with simultaneous push and pop: pop happens, push refused
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    check("fullpp_pre_count", bus.COUNT, 4);
    step(1'b1, 8'h05, 1'b1);
    check("fullpp_count", bus.COUNT, 3);
    check("fullpp_head", bus.DOUT, 8'h02);
    check("fullpp_xready", bus.XREADY, 1);
    check("fullpp_ovf", bus.OVERFLOW, 1);
    step(1'b0, 8'h00, 1'b1);
    check("fullpp_03", bus.DOUT, 8'h03);
    step(1'b0, 8'h00, 1'b1);
    check("fullpp_04", bus.DOUT, 8'h04);
    step(1'b0, 8'h00, 1'b1);
    check("fullpp_empty", bus.DVALID, 0);
    check("fullpp_count_end", bus.COUNT, 0);

    // Reset mid-stream, asserted between clock edges
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    check("mid_pre_count", bus.COUNT, 3);
    bus.XVALID = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check("mid_rst_count", bus.COUNT, 0);
    check("mid_rst_dvalid", bus.DVALID, 0);
    check("mid_rst_dout", bus.DOUT, 0);
    check("mid_rst_xready", bus.XREADY, 0);
    check("mid_rst_ovf", bus.OVERFLOW, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("mid_rel_xready", bus.XREADY, 1);
    step(1'b1, 8'h77, 1'b0);
    check("mid_head", bus.DOUT, 8'h77);
    check("mid_head_count", bus.COUNT, 1);
    check("mid_head_dvalid", bus.DVALID, 1);
    step(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
